// File: rtl/param_pack_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : param_pack_fifo_pkg
//  Purpose  : Shared constants for the param_pack_fifo slice:
//             - default field widths and FIFO depth
//             - drop counter width and its saturation value
//             - pointer-width helper built on $clog2
//  Revision : 1.0  initial release
// ============================================================================
package param_pack_fifo_pkg;

    // Default field widths and FIFO depth.
    localparam int DEF_A_W   = 1;
    localparam int DEF_B_W   = 2;
    localparam int DEF_C_W   = 3;
    localparam int DEF_DEPTH = 4;

    // Refused-transfer counter; it saturates rather than wrapping.
    localparam int                DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_SAT = 8'hFF;

    // Pointer width for a power-of-two depth. It is never allowed to
    // collapse to zero bits.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : param_pack_fifo_pkg
`default_nettype wire

// File: rtl/param_pack_ram.sv
`default_nettype none
// ============================================================================
//  Module   : param_pack_ram
//  Purpose  : DEPTH x W storage array for param_pack_fifo.
//             - synchronous write
//             - asynchronous read, so the FIFO head word falls through
//               without an extra register stage
//             The contents are deliberately not reset.
//  Ports    : clock  - write clock
//             we     - write enable
//             waddr  - write address
//             wdata  - write data
//             raddr  - read address
//             rdata  - read data (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module param_pack_ram
    import param_pack_fifo_pkg::*;
#(
    parameter int W     = DEF_A_W + DEF_B_W + DEF_C_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [W-1:0]              wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [W-1:0]              rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : param_pack_ram
`default_nettype wire

// File: rtl/param_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : param_pack_fifo
//  Purpose  : Packs three input fields {c,b,a} (a in the LSBs) into one word
//             on every accepted transfer and queues it in a DEPTH-entry
//             first-word-fall-through FIFO. The FIFO drains through a
//             valid/ready port and reports its occupancy.
//  Ports    : clock      - sole clock, rising edge
//             reset      - synchronous, active-high
//             in_valid   - producer offers a/b/c
//             in_ready   - buffer can accept (held low while reset is high)
//             a, b, c    - input fields, widths A_W, B_W, C_W
//             out_valid  - head word available
//             out_ready  - consumer takes the head word
//             out_data   - head word, zero when empty
//             count      - occupancy, 0..DEPTH
//             drop_cnt   - saturating count of refused offers
//                          (only with PARAM_PACK_DROP_CNT_EN)
//  Config   : `define PARAM_PACK_DROP_CNT_EN adds the drop_cnt port
//             and its counter.
//  Revision : 1.0  initial release
// ============================================================================
module param_pack_fifo
    import param_pack_fifo_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int C_W   = DEF_C_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [A_W-1:0]            a,
    input  logic [B_W-1:0]            b,
    input  logic [C_W-1:0]            c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [A_W+B_W+C_W-1:0]    out_data,
    output logic [ptr_w(DEPTH):0]     count
`ifdef PARAM_PACK_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]         drop_cnt
`endif
);

    localparam int W  = A_W + B_W + C_W;
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW:0]   c_full     = (PW+1)'(DEPTH);
    localparam logic [PW:0]   c_cnt_one  = (PW+1)'(1);
    localparam logic [PW-1:0] c_ptr_one  = PW'(1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_wdata;
    logic [W-1:0]  w_rdata;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    // in_ready depends only on the current occupancy. A pop in the same
    // cycle therefore never opens a slot for a push when the FIFO is full.
    assign in_ready  = !reset && (r_count != c_full);
    assign out_valid = (r_count != '0);

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready && !reset;
    assign w_wdata = {c, b, a};

    // Memory is never reset. Gating with out_valid keeps stale or
    // uninitialised words off the output.
    assign out_data = out_valid ? w_rdata : '0;
    assign count    = r_count;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    param_pack_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wdata),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // DEPTH is a power of two, so the pointers wrap to 0 by plain
    // overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PARAM_PACK_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Refused-offer counter: counts cycles where the producer offers data
    // but the FIFO is full. It stops at DROP_SAT.
    // ------------------------------------------------------------------
    logic [DROP_W-1:0] r_drop_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (in_valid && !in_ready && (r_drop_cnt != DROP_SAT)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule : param_pack_fifo
`default_nettype wire
